aes_sub_shift: RTL and testbench

Iterative SubBytes + ShiftRows stage of the AES encryption round, sitting directly upstream of the combinational MixColumns block. It accepts one 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through LANES S-box instances. It then applies ShiftRows and presents the registered result to the MixColumns input, holding it until the consumer accepts it.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes_sub_shift.sv | 94 +++++++++
 tb/tb_aes_sub_shift.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, widths and the ShiftRows permutation.
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    // Column-major state, byte k at bits [127-8k -: 8], row = k%4, column = k/4.
    // Output (r,c) takes input (r,(c+r) mod 4): row r rotates left by r.
    function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[BLOCK_W-1-BYTE_W*(4*c+r) -: BYTE_W] =
                    s[BLOCK_W-1-BYTE_W*(4*((c+r)%4)+r) -: BYTE_W];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: stateless 256-entry byte lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout
);

    // Entry 0 occupies the most significant byte; one 128-bit row per high nibble.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX[2047 - BYTE_W*int'(din) -: BYTE_W];

endmodule

// File: rtl/aes_sub_shift.sv
// Iterative SubBytes (LANES bytes per cycle) followed by ShiftRows, with a
// registered, held result feeding MixColumns.
module aes_sub_shift
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BLOCK_W-1:0] i_block,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [BLOCK_W-1:0] o_block
);

    localparam int N     = 16 / LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t             state;
    state_t             state_nxt;
    // cnt indexes byte groups; the group's first byte is cnt*LANES.
    logic [CNT_W-1:0]   cnt;
    logic [BLOCK_W-1:0] work;
    logic [BLOCK_W-1:0] work_nxt;
    logic [BYTE_W-1:0]  sb_in  [LANES];
    logic [BYTE_W-1:0]  sb_out [LANES];
    logic               accept;
    logic               last;

    assign accept  = (state == IDLE) && i_valid;
    assign last    = (state == SUB) && (cnt == CNT_LAST);
    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    for (genvar g = 0; g < LANES; g++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (sb_in[g]),
            .dout (sb_out[g])
        );
    end

    // Pick the current byte group and merge its substituted values back into the state.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
        work_nxt = work;
        for (int g = 0; g < LANES; g++) begin
            sb_in[g] = work[BLOCK_W-1-BYTE_W*(int'(cnt)*LANES+g) -: BYTE_W];
            work_nxt[BLOCK_W-1-BYTE_W*(int'(cnt)*LANES+g) -: BYTE_W] = sb_out[g];
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, leave SUB on the last group, hand off in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid) state_nxt = SUB;
            SUB:     if (last)    state_nxt = DONE;
            DONE:    if (i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture the block, substitute one group per cycle, latch the shifted result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            work    <= '0;
            o_block <= '0;
        end else if (accept) begin
            work <= i_block;
            cnt  <= '0;
        end else if (state == SUB) begin
            work <= work_nxt;
            cnt  <= last ? '0 : cnt + 1'b1;
            if (last) begin
                o_block <= shift_rows(work_nxt);
            end
        end
    end

endmodule

// File: tb/tb_aes_sub_shift.sv
// Self-checking bench for aes_sub_shift: one instance per LANES setting,
// compared against an algebraic (GF(2^8)) S-box and array-based ShiftRows model.
module tb_aes_sub_shift;

    localparam int NDUT = 5;

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
        string        name;
    } vec_t;

    logic         i_clk;
    logic         i_rst_n;
    logic         x_valid  [NDUT];
    logic         x_iready [NDUT];
    logic [127:0] x_blk    [NDUT];
    logic         x_ordy   [NDUT];
    logic         x_ovalid [NDUT];
    logic [127:0] x_oblk   [NDUT];

    int           n_tests;
    int           n_fail;
    logic [7:0]   sb [256];

    // Free-running 10 ns clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Instance 0 is LANES=4; the others cover 1, 2, 8 and 16.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
        aes_sub_shift #(.LANES(L)) dut (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_valid (x_valid[g]),
            .o_ready (x_ordy[g]),
            .i_block (x_blk[g]),
            .o_valid (x_ovalid[g]),
            .i_ready (x_iready[g]),
            .o_block (x_oblk[g])
        );
    end

    function automatic int lanes_of(input int idx);
        case (idx)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_block(input logic [127:0] din);
        logic [7:0]   st [4][4];
        logic [127:0] o;
        for (int k = 0; k < 16; k++) st[k % 4][k / 4] = sb[din[127-8*k -: 8]];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = st[r][(c + r) % 4];
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one block, check latency and result, stall rdly cycles, then hand off.
    task automatic run_block(input int idx, input logic [127:0] din, input logic [127:0] exp,
                             input string name, input int rdly);
        int n;
        int cyc;
        n = 16 / lanes_of(idx);
        cyc = 0;
        while (!x_ordy[idx] && cyc < 50) begin
            @(negedge i_clk);
            cyc++;
        end
        check({name, " ready"}, 128'(x_ordy[idx]), 128'd1);
        x_valid[idx] = 1'b1;
        x_blk[idx]   = din;
        @(negedge i_clk);
        x_valid[idx] = 1'b0;
        x_blk[idx]   = {$urandom, $urandom, $urandom, $urandom};
        cyc = 0;
        while (!x_ovalid[idx] && cyc < 100) begin
            @(negedge i_clk);
            cyc++;
        end
        check({name, " latency"}, 128'(cyc), 128'(n));
        check({name, " block"}, x_oblk[idx], exp);
        repeat (rdly) @(negedge i_clk);
        if (rdly > 0) check({name, " held"}, 128'(x_ovalid[idx]), 128'd1);
        x_iready[idx] = 1'b1;
        @(negedge i_clk);
        x_iready[idx] = 1'b0;
        check({name, " valid drop"}, 128'(x_ovalid[idx]), 128'd0);
        check({name, " ready back"}, 128'(x_ordy[idx]), 128'd1);
        check({name, " block kept"}, x_oblk[idx], exp);
    endtask

    // Hard stop in case a stimulus sequence stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence.
    initial begin
        vec_t         vecs [4];
        logic [127:0] fips_in;
        logic [127:0] fips_out;
        logic [127:0] d;
        int           tv [2];
        logic [127:0] bv [2];
        int           seen;
        int           t;
        int           cyc;

        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

        fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        fips_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        vecs[0] = '{din: '0,                                      exp: {16{8'h63}}, name: "zero"};
        vecs[1] = '{din: fips_in,                                 exp: fips_out,    name: "fips"};
        vecs[2] = '{din: '1,                                      exp: {16{8'h16}}, name: "ones"};
        vecs[3] = '{din: 128'h000102030405060708090a0b0c0d0e0f,
                    exp: 128'h636b6776f201ab7b30d777c5fe7c6f2b,  name: "order"};

        for (int i = 0; i < NDUT; i++) begin
            x_valid[i]  = 1'b0;
            x_iready[i] = 1'b0;
            x_blk[i]    = '0;
        end
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst ready", 128'(x_ordy[0]), 128'd1);
        check("rst valid", 128'(x_ovalid[0]), 128'd0);
        check("rst block", x_oblk[0], 128'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("post-rst ready", 128'(x_ordy[0]), 128'd1);
        check("post-rst valid", 128'(x_ovalid[0]), 128'd0);

        // Directed vectors on LANES=4.
        for (int i = 0; i < 4; i++) run_block(0, vecs[i].din, vecs[i].exp, vecs[i].name, 0);
        check("order vs model", ref_block(vecs[3].din), x_oblk[0]);

        // FIPS vector on the other lane counts (latency 16, 8, 2, 1).
        for (int i = 1; i < NDUT; i++) run_block(i, fips_in, fips_out, $sformatf("fips L%0d", lanes_of(i)), 0);

        // Backpressure: result held for 10 cycles, extra i_valid pulse ignored.
        x_valid[0] = 1'b1;
        x_blk[0]   = fips_in;
        @(negedge i_clk);
        x_valid[0] = 1'b0;
        cyc = 0;
        while (!x_ovalid[0] && cyc < 100) begin
            @(negedge i_clk);
            cyc++;
        end
        check("bp latency", 128'(cyc), 128'd4);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                x_valid[0] = 1'b1;
                x_blk[0]   = '1;
            end else begin
                x_valid[0] = 1'b0;
            end
            @(negedge i_clk);
            check("bp valid", 128'(x_ovalid[0]), 128'd1);
            check("bp ready", 128'(x_ordy[0]), 128'd0);
            check("bp block", x_oblk[0], fips_out);
        end
        x_valid[0]  = 1'b0;
        x_iready[0] = 1'b1;
        @(negedge i_clk);
        check("bp release valid", 128'(x_ovalid[0]), 128'd0);
        check("bp release ready", 128'(x_ordy[0]), 128'd1);
        seen = 0;
        repeat (12) begin
            @(negedge i_clk);
            if (x_ovalid[0]) seen++;
        end
        check("bp pulse not captured", 128'(seen), 128'd0);

        // Back-to-back: i_valid and i_ready high, zeros then ones.
        x_valid[0] = 1'b1;
        x_blk[0]   = '0;
        @(negedge i_clk);
        x_blk[0] = '1;
        t = 1;
        seen = 0;
        tv[0] = 0;
        tv[1] = 0;
        bv[0] = '0;
        bv[1] = '0;
        while (seen < 2 && t < 60) begin
            if (x_ovalid[0]) begin
                tv[seen] = t;
                bv[seen] = x_oblk[0];
                seen++;
            end
            @(negedge i_clk);
            t++;
        end
        x_valid[0] = 1'b0;
        check("b2b count", 128'(seen), 128'd2);
        check("b2b first latency", 128'(tv[0] - 1), 128'd4);
        check("b2b spacing", 128'(tv[1] - tv[0]), 128'd6);
        check("b2b first block", bv[0], {16{8'h63}});
        check("b2b second block", bv[1], {16{8'h16}});
        repeat (10) @(negedge i_clk);
        x_iready[0] = 1'b0;

        // Reset asserted after 2 of 4 SUB cycles.
        d = x_oblk[0];
        check("pre-abort block nonzero", 128'(d != '0), 128'd1);
        x_valid[0] = 1'b1;
        x_blk[0]   = fips_in;
        @(negedge i_clk);
        x_valid[0] = 1'b0;
        repeat (2) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("abort valid", 128'(x_ovalid[0]), 128'd0);
        check("abort ready", 128'(x_ordy[0]), 128'd1);
        check("abort block", x_oblk[0], 128'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        x_iready[0] = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (x_ovalid[0]) seen++;
        end
        x_iready[0] = 1'b0;
        check("aborted block never emitted", 128'(seen), 128'd0);
        check("after abort block", x_oblk[0], 128'd0);

        // Random blocks against the reference model.
        for (int i = 0; i < 20; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            run_block(0, d, ref_block(d), $sformatf("rand L4 #%0d", i), int'($urandom_range(0, 3)));
        end
        for (int k = 1; k < NDUT; k++) begin
            for (int i = 0; i < 3; i++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                run_block(k, d, ref_block(d), $sformatf("rand L%0d #%0d", lanes_of(k), i),
                          int'($urandom_range(0, 2)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
